// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the 4x4 keypad scan encoder.
//   scan_state_t   : column-scan FSM states (dwell, sample, evaluate)
//   result_kind_t  : classification of one full scan (none / single / multi)
//   scan_result_t  : {kind, code} as produced by one full scan
//   idx_to_onecold : 2-bit index -> active-low one-cold nibble
//   onecold_to_idx : active-low nibble -> index of lowest-index low bit
//   count_low      : number of low bits in a nibble
//   results_equal  : scan result comparison (code only matters for SINGLE)
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_DWELL  = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } result_kind_t;

    typedef struct packed {
        result_kind_t kind;
        logic [3:0]   code;
    } scan_result_t;

    // Index 0 is the MSB being low, matching the keypad pin ordering.
    function automatic logic [3:0] idx_to_onecold(input logic [1:0] idx);
        logic [3:0] v;
        case (idx)
            2'd0:    v = 4'b0111;
            2'd1:    v = 4'b1011;
            2'd2:    v = 4'b1101;
            2'd3:    v = 4'b1110;
            default: v = 4'b0111;
        endcase
        return v;
    endfunction

    // Lowest index wins when several bits are low; all-high returns 3,
    // callers only use the result when at least one bit is low.
    function automatic logic [1:0] onecold_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[3] == 1'b0) begin
            idx = 2'd0;
        end else if (v[2] == 1'b0) begin
            idx = 2'd1;
        end else if (v[1] == 1'b0) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [2:0] count_low(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == 1'b0) begin
                n = n + 3'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    function automatic logic results_equal(input scan_result_t a, input scan_result_t b);
        logic eq;
        if (a.kind != b.kind) begin
            eq = 1'b0;
        end else if (a.kind == RES_SINGLE) begin
            eq = (a.code == b.code);
        end else begin
            eq = 1'b1;
        end
        return eq;
    endfunction

endpackage

// File: rtl/keypad_scan_encoder_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a bus of independent asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both stages load RESET_VAL)
//   i_d   : asynchronous input bus
//   o_q   : synchronized output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter: first stage may go metastable, second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_encoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_encoder
// Scans a 4x4 matrix keypad one column at a time, encodes the single pressed
// key as {col_idx, row_idx}, debounces over whole scans and reports the
// committed key state.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   row_n     : raw active-low row returns (asynchronous)
//   col_n     : active-low one-cold column strobe (registered)
//   key_code  : committed scan code {col_idx[1:0], row_idx[1:0]}
//   key_valid : exactly one key committed as held
//   key_press : one-cycle pulse when a new single key is committed
//   multi_key : two or more keys committed as held
// Each column is driven for SCAN_DIV cycles (the last one being SAMPLE), then
// one EVAL cycle closes the scan: period = 4*SCAN_DIV + 1 cycles.
// -----------------------------------------------------------------------------
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_press,
    output logic       multi_key
);

    localparam int               CNT_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int               STB_W      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 2);
    localparam logic [STB_W-1:0] STABLE_MAX = STB_W'(DEBOUNCE_SCANS);

    logic [3:0]       w_row_sync;

    scan_state_t      r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_dwell_cnt,  w_dwell_nxt;
    logic [1:0]       r_col_idx,    w_col_idx_nxt;
    logic [3:0]       r_col_n,      w_col_n_nxt;
    logic [1:0]       r_hit_cnt,    w_hit_nxt;
    logic [3:0]       r_first_code, w_first_code_nxt;
    scan_result_t     r_prev,       w_prev_nxt;
    logic [STB_W-1:0] r_stable_cnt, w_stable_nxt;
    scan_result_t     r_committed,  w_committed_nxt;
    logic [3:0]       r_key_code,   w_key_code_nxt;
    logic             r_key_valid,  w_key_valid_nxt;
    logic             r_key_press,  w_key_press_nxt;
    logic             r_multi_key,  w_multi_key_nxt;

    logic [2:0]       w_low_cnt;
    logic [2:0]       w_hit_sum;
    scan_result_t     w_scan;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (row_n),
        .o_q   (w_row_sync)
    );

    // Row hit counting and classification of the scan accumulated so far.
    always_comb begin
        w_low_cnt = count_low(w_row_sync);
        w_hit_sum = {1'b0, r_hit_cnt} + w_low_cnt;
        w_scan    = '{kind: RES_NONE, code: 4'd0};
        case (r_hit_cnt)
            2'd0:    w_scan = '{kind: RES_NONE,   code: 4'd0};
            2'd1:    w_scan = '{kind: RES_SINGLE, code: r_first_code};
            default: w_scan = '{kind: RES_MULTI,  code: 4'd0};
        endcase
    end

    // Scan FSM, debounce and commit logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_dwell_nxt      = r_dwell_cnt;
        w_col_idx_nxt    = r_col_idx;
        w_hit_nxt        = r_hit_cnt;
        w_first_code_nxt = r_first_code;
        w_prev_nxt       = r_prev;
        w_stable_nxt     = r_stable_cnt;
        w_committed_nxt  = r_committed;
        w_key_code_nxt   = r_key_code;
        w_key_valid_nxt  = r_key_valid;
        w_key_press_nxt  = 1'b0;
        w_multi_key_nxt  = r_multi_key;

        case (r_state)
            ST_DWELL: begin
                w_dwell_nxt = r_dwell_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_dwell_cnt == DWELL_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_state_nxt = ST_DWELL;
                end
            end

            ST_SAMPLE: begin
                w_dwell_nxt = '0;
                // Hit count only needs to distinguish 0, 1 and "2 or more".
                if (w_hit_sum >= 3'd2) begin
                    w_hit_nxt = 2'd2;
                end else begin
                    w_hit_nxt = w_hit_sum[1:0];
                end
                if ((r_hit_cnt == 2'd0) && (w_low_cnt != 3'd0)) begin
                    w_first_code_nxt = {r_col_idx, onecold_to_idx(w_row_sync)};
                end else begin
                    w_first_code_nxt = r_first_code;
                end
                if (r_col_idx == 2'd3) begin
                    w_state_nxt = ST_EVAL;
                end else begin
                    w_col_idx_nxt = r_col_idx + 2'd1;
                    w_state_nxt   = ST_DWELL;
                end
            end

            ST_EVAL: begin
                if (results_equal(w_scan, r_prev)) begin
                    if (r_stable_cnt >= STABLE_MAX) begin
                        w_stable_nxt = STABLE_MAX;
                    end else begin
                        w_stable_nxt = r_stable_cnt + {{(STB_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_stable_nxt = {{(STB_W-1){1'b0}}, 1'b1};
                end
                w_prev_nxt = w_scan;

                // Commit only on a change, so a held key pulses exactly once.
                if ((w_stable_nxt == STABLE_MAX) && !results_equal(w_scan, r_committed)) begin
                    w_committed_nxt = w_scan;
                    case (w_scan.kind)
                        RES_SINGLE: begin
                            w_key_code_nxt  = w_scan.code;
                            w_key_valid_nxt = 1'b1;
                            w_multi_key_nxt = 1'b0;
                            w_key_press_nxt = 1'b1;
                        end
                        RES_MULTI: begin
                            w_key_valid_nxt = 1'b0;
                            w_multi_key_nxt = 1'b1;
                        end
                        default: begin
                            w_key_valid_nxt = 1'b0;
                            w_multi_key_nxt = 1'b0;
                        end
                    endcase
                end else begin
                    w_committed_nxt = r_committed;
                end

                w_hit_nxt        = 2'd0;
                w_first_code_nxt = 4'd0;
                w_dwell_nxt      = '0;
                w_col_idx_nxt    = 2'd0;
                w_state_nxt      = ST_DWELL;
            end

            default: begin
                w_hit_nxt        = 2'd0;
                w_first_code_nxt = 4'd0;
                w_dwell_nxt      = '0;
                w_col_idx_nxt    = 2'd0;
                w_state_nxt      = ST_DWELL;
            end
        endcase

        // Strobe is derived from the next column so col_n tracks col_idx exactly.
        w_col_n_nxt = idx_to_onecold(w_col_idx_nxt);
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_DWELL;
            r_dwell_cnt  <= '0;
            r_col_idx    <= 2'd0;
            r_col_n      <= 4'b0111;
            r_hit_cnt    <= 2'd0;
            r_first_code <= 4'd0;
            r_prev       <= '{kind: RES_NONE, code: 4'd0};
            r_stable_cnt <= '0;
            r_committed  <= '{kind: RES_NONE, code: 4'd0};
            r_key_code   <= 4'd0;
            r_key_valid  <= 1'b0;
            r_key_press  <= 1'b0;
            r_multi_key  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dwell_cnt  <= w_dwell_nxt;
            r_col_idx    <= w_col_idx_nxt;
            r_col_n      <= w_col_n_nxt;
            r_hit_cnt    <= w_hit_nxt;
            r_first_code <= w_first_code_nxt;
            r_prev       <= w_prev_nxt;
            r_stable_cnt <= w_stable_nxt;
            r_committed  <= w_committed_nxt;
            r_key_code   <= w_key_code_nxt;
            r_key_valid  <= w_key_valid_nxt;
            r_key_press  <= w_key_press_nxt;
            r_multi_key  <= w_multi_key_nxt;
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_press = r_key_press;
    assign multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_encoder
// Scoreboard bench: stimulus pushes the expected output event
// {key_press, key_valid, multi_key, key_code} for every commit it provokes;
// a negedge monitor pops and compares whenever the DUT shows an event
// (key_press high, or key_valid / multi_key changing).
// SCAN_DIV=4, DEBOUNCE_SCANS=2 -> 17-cycle scan period.
// -----------------------------------------------------------------------------
module tb_keypad_scan_encoder;

    localparam int SCAN_P = 17;
    localparam int BUDGET = 3 * SCAN_P + 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;
    logic       multi_key;

    logic [15:0] keys;      // keys[{col,row}] = 1 when pressed
    logic [6:0]  exp_q[$];  // {press, valid, multi, code}
    int          checks;
    int          failures;
    logic        mon_valid;
    logic        mon_multi;

    keypad_scan_encoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_press (key_press),
        .multi_key (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad matrix: a pressed key shorts its column strobe to its row.
    always_comb begin
        row_n = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_n[3-c] == 1'b0 && keys[c*4+r] == 1'b1) begin
                    row_n[3-r] = 1'b0;
                end
            end
        end
    end

    // Monitor: every output event must match the oldest expectation.
    always @(negedge clk) begin
        if (key_press === 1'b1 || key_valid !== mon_valid || multi_key !== mon_multi) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_event t=%0t got press=%b valid=%b multi=%b code=%h",
                         $time, key_press, key_valid, multi_key, key_code);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({key_press, key_valid, multi_key, key_code} !== e) begin
                    failures = failures + 1;
                    $display("FAIL event t=%0t got press=%b valid=%b multi=%b code=%h want press=%b valid=%b multi=%b code=%h",
                             $time, key_press, key_valid, multi_key, key_code, e[6], e[5], e[4], e[3:0]);
                end
            end
        end
        mon_valid <= key_valid;
        mon_multi <= multi_key;
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic expect_event(input logic p, input logic v, input logic m, input logic [3:0] c);
        exp_q.push_back({p, v, m, c});
    endtask

    // Bounded wait until every pushed expectation has been seen.
    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL %s timeout pending=%0d after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // Returns at the first negedge of a new scan (col_n just went 1110 -> 0111).
    task automatic wait_scan_start();
        logic [3:0] last;
        int n;
        last = col_n;
        n = 0;
        forever begin
            @(negedge clk);
            if (last == 4'b1110 && col_n == 4'b0111) break;
            last = col_n;
            n++;
            if (n > 2 * SCAN_P) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL scan_start timeout col_n=%b", col_n);
                break;
            end
        end
    endtask

    task automatic idle_scans(input int n);
        repeat (n * SCAN_P) @(negedge clk);
    endtask

    logic [3:0] col_seq [18];

    initial begin
        checks    = 0;
        failures  = 0;
        mon_valid = 1'b0;
        mon_multi = 1'b0;
        keys      = 16'h0000;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold_col_n", col_n, 4'b0111);

        // Reset release and one full scan of column strobes.
        col_seq = '{4'b0111, 4'b0111, 4'b0111, 4'b0111,
                    4'b1011, 4'b1011, 4'b1011, 4'b1011,
                    4'b1101, 4'b1101, 4'b1101, 4'b1101,
                    4'b1110, 4'b1110, 4'b1110, 4'b1110,
                    4'b1110, 4'b0111};
        rst_n = 1'b1;
        #1;
        check("rst_key_code", key_code, 4'b0000);
        check("rst_flags", {1'b0, key_valid, key_press, multi_key}, 4'b0000);
        for (int k = 0; k < 18; k++) begin
            check($sformatf("col_seq[%0d]", k), col_n, col_seq[k]);
            @(negedge clk);
        end

        // Single key col1/row2 -> code 0x6, one press, then a long hold.
        wait_scan_start();
        keys[6] = 1'b1;
        expect_event(1'b1, 1'b1, 1'b0, 4'h6);
        wait_drain("single_press", BUDGET);
        idle_scans(10);

        // Release: valid falls, code holds.
        wait_scan_start();
        keys = 16'h0000;
        expect_event(1'b0, 1'b0, 1'b0, 4'h6);
        wait_drain("release", BUDGET);

        // Bounce: key reads off/on alternately on successive scans, then held.
        for (int s = 0; s < 5; s++) begin
            wait_scan_start();
            keys[6] = (s % 2 == 1);
        end
        wait_scan_start();
        keys[6] = 1'b1;
        expect_event(1'b1, 1'b1, 1'b0, 4'h6);
        wait_drain("bounce_hold", BUDGET);
        check("bounce_no_press_pending", {3'b000, key_press}, 4'b0000);

        // Key change without release: 0x6 -> col2/row1 = 0x9.
        wait_scan_start();
        keys = 16'h0000;
        keys[9] = 1'b1;
        expect_event(1'b1, 1'b1, 1'b0, 4'h9);
        wait_drain("key_change", BUDGET);

        // Release, then two keys together: multi, no press, code holds.
        wait_scan_start();
        keys = 16'h0000;
        expect_event(1'b0, 1'b0, 1'b0, 4'h9);
        wait_drain("release2", BUDGET);
        wait_scan_start();
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        expect_event(1'b0, 1'b0, 1'b1, 4'h9);
        wait_drain("multi", BUDGET);
        idle_scans(2);

        // Drop col3/row3: single key 0x0 pressed out of multi.
        wait_scan_start();
        keys[15] = 1'b0;
        expect_event(1'b1, 1'b1, 1'b0, 4'h0);
        wait_drain("multi_to_single", BUDGET);

        // Move to 0x6 so the reset test can see key_code clear.
        wait_scan_start();
        keys = 16'h0000;
        keys[6] = 1'b1;
        expect_event(1'b1, 1'b1, 1'b0, 4'h6);
        wait_drain("to_six", BUDGET);

        // Reset in the SAMPLE cycle of column 1 with the key held.
        wait_scan_start();
        repeat (7) @(negedge clk);
        check("pre_reset_col_n", col_n, 4'b1011);
        expect_event(1'b0, 1'b0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_col_n", col_n, 4'b0111);
        check("midrst_key_code", key_code, 4'b0000);
        check("midrst_flags", {1'b0, key_valid, key_press, multi_key}, 4'b0000);
        wait_drain("midrst_event", 4);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_event(1'b1, 1'b1, 1'b0, 4'h6);
        wait_drain("redetect", BUDGET);
        idle_scans(3);
        check("final_code", key_code, 4'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
